// File: rtl/arc4_pkg.sv
// ---------------------------------------------------------------------------
// arc4_pkg
// Shared ARC4 definitions used by the S-box init, key-schedule (ksa) and
// PRGA stages.
//   SBOX_DEPTH  : number of bytes in the S permutation
//   KEY_BYTES   : key length in bytes
//   ksa_state_t : key-schedule FSM encoding
//   key_byte()  : selects the key byte used at S index i (i mod KEY_BYTES)
// ---------------------------------------------------------------------------
package arc4_pkg;

    localparam int unsigned SBOX_DEPTH = 256;
    localparam int unsigned KEY_BYTES  = 3;

    typedef enum logic [2:0] {
        KSA_IDLE    = 3'd0,
        KSA_READ_I  = 3'd1,
        KSA_READ_J  = 3'd2,
        KSA_WRITE_J = 3'd3,
        KSA_WRITE_I = 3'd4
    } ksa_state_t;

    // Key byte 0 sits in the most significant byte of the key word.
    function automatic logic [7:0] key_byte(input logic [23:0] key, input logic [7:0] idx);
        logic [7:0] sel;
        sel = idx % 8'(KEY_BYTES);
        unique case (sel)
            8'd0:    key_byte = key[23:16];
            8'd1:    key_byte = key[15:8];
            default: key_byte = key[7:0];
        endcase
    endfunction

endpackage

// File: rtl/ksa.sv
// ---------------------------------------------------------------------------
// ksa
// ARC4 key-scheduling algorithm over an external 256-byte S-memory that has
// already been initialised to S[i] = i.
//
//   j = 0; for i = 0..255: j = j + S[i] + key[i mod 3]; swap S[i], S[j]
//
// Each iteration takes four cycles (READ_I, READ_J, WRITE_J, WRITE_I), so a
// full run keeps rdy low for 1024 cycles.
//
// Ports
//   clk     in   1  clock, rising edge
//   rst     in   1  synchronous active-high reset
//   en      in   1  start request, only looked at while rdy = 1
//   rdy     out  1  idle, able to accept en
//   key     in  24  key; key[23:16] is byte 0, key[7:0] is byte 2
//   addr    out  8  S-memory address
//   rddata  in   8  S-memory read data, one cycle after addr (sync read)
//   wrdata  out  8  S-memory write data
//   wren    out  1  S-memory write enable, commits at the end of the cycle
// ---------------------------------------------------------------------------
module ksa
    import arc4_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        rdy,
    input  logic [23:0] key,
    output logic [7:0]  addr,
    input  logic [7:0]  rddata,
    output logic [7:0]  wrdata,
    output logic        wren
);

    localparam logic [7:0] LAST_I = 8'(SBOX_DEPTH - 1);

    ksa_state_t  r_state;
    logic [7:0]  r_i;
    logic [7:0]  r_j;
    logic [7:0]  r_si;
    logic [7:0]  r_sj;
    logic [23:0] r_key;

    // New j, formed while S[i] is on rddata during READ_J. 8-bit wrap is
    // the mod-256 of the algorithm.
    logic [7:0]  w_jn;

    assign w_jn = r_j + rddata + key_byte(r_key, r_i);

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= KSA_IDLE;
            r_i     <= 8'd0;
            r_j     <= 8'd0;
            r_si    <= 8'd0;
            r_sj    <= 8'd0;
            r_key   <= 24'd0;
        end else begin
            unique case (r_state)
                KSA_IDLE: begin
                    if (en) begin
                        // Key is frozen here; later changes on key are ignored.
                        r_key   <= key;
                        r_i     <= 8'd0;
                        r_j     <= 8'd0;
                        r_state <= KSA_READ_I;
                    end
                end
                KSA_READ_I: begin
                    r_state <= KSA_READ_J;
                end
                KSA_READ_J: begin
                    r_si    <= rddata;
                    r_j     <= w_jn;
                    r_state <= KSA_WRITE_J;
                end
                KSA_WRITE_J: begin
                    r_sj    <= rddata;
                    r_state <= KSA_WRITE_I;
                end
                KSA_WRITE_I: begin
                    if (r_i == LAST_I) begin
                        r_state <= KSA_IDLE;
                    end else begin
                        r_i     <= r_i + 8'd1;
                        r_state <= KSA_READ_I;
                    end
                end
                default: begin
                    r_state <= KSA_IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Memory-port outputs, decoded from the current state.
    // When i == j both writes store the original S[i], leaving S unchanged,
    // so no special case is needed.
    // -----------------------------------------------------------------------
    always_comb begin
        rdy    = 1'b0;
        addr   = 8'd0;
        wrdata = 8'd0;
        wren   = 1'b0;
        unique case (r_state)
            KSA_IDLE: begin
                rdy = 1'b1;
            end
            KSA_READ_I: begin
                addr = r_i;
            end
            KSA_READ_J: begin
                addr = w_jn;
            end
            KSA_WRITE_J: begin
                addr   = r_j;
                wrdata = r_si;
                wren   = 1'b1;
            end
            KSA_WRITE_I: begin
                addr   = r_i;
                wrdata = r_sj;
                wren   = 1'b1;
            end
            default: begin
                rdy = 1'b0;
            end
        endcase
    end

endmodule
